// File: rtl/spi_master_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_master_top                                                  |
// | Brief    : Pmod DA2 SPI master; 16-bit DAC frames from switches, pattern,  |
// |            ramp or sine. Macro START_DEBOUNCE_EN debounces start_btn.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module spi_master_top #(
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int GAP_CYCLES      = 16
) (
   input  logic       clk,
   input  logic       rst_btn,
   input  logic [1:0] mode_sw,
   input  logic       start_btn,
   input  logic [3:0] clk_div_sw,
   input  logic [7:0] data_sw,
   output logic       led_busy,
   output logic [1:0] led_mode,
   output logic       spi_cs_n,
   output logic       spi_sclk,
   output logic       spi_mosi
);
   localparam int                 c_gap_w    = $clog2(GAP_CYCLES + 1);
   localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   generate
      if (GAP_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_chk
         $error("spi_master_top: GAP_CYCLES and DEBOUNCE_CYCLES must be >= 1");
      end
   endgenerate

   function automatic logic [11:0] pat_lut(input logic [1:0] idx);
      case (idx)
         2'd0:    pat_lut = 12'h000;
         2'd1:    pat_lut = 12'h555;
         2'd2:    pat_lut = 12'hAAA;
         default: pat_lut = 12'hFFF;
      endcase
   endfunction

   function automatic logic [11:0] sine_lut(input logic [3:0] idx);
      case (idx)
         4'd0:    sine_lut = 12'h800;
         4'd1:    sine_lut = 12'hB0F;
         4'd2:    sine_lut = 12'hDA7;
         4'd3:    sine_lut = 12'hF63;
         4'd4:    sine_lut = 12'hFFF;
         4'd5:    sine_lut = 12'hF63;
         4'd6:    sine_lut = 12'hDA7;
         4'd7:    sine_lut = 12'hB0F;
         4'd8:    sine_lut = 12'h800;
         4'd9:    sine_lut = 12'h4F1;
         4'd10:   sine_lut = 12'h259;
         4'd11:   sine_lut = 12'h09D;
         4'd12:   sine_lut = 12'h001;
         4'd13:   sine_lut = 12'h09D;
         4'd14:   sine_lut = 12'h259;
         default: sine_lut = 12'h4F1;
      endcase
   endfunction

   logic btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
`ifdef START_DEBOUNCE_EN
   localparam int                c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
   logic [c_db_w-1:0] db_cnt_q, db_cnt_d;
   logic              db_fired_q, db_fired_d;
`else
   logic btn_prev_q, btn_prev_d;
`endif

   state_t             state_q, state_d;
   logic [15:0]        shreg_q, shreg_d;
   logic [3:0]         div_q, div_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [3:0]         bit_q, bit_d;
   logic [c_gap_w-1:0] gap_q, gap_d;
   logic               cs_n_q, cs_n_d;
   logic               sclk_q, sclk_d;
   logic               mosi_q, mosi_d;
   logic               busy_q, busy_d;
   logic [1:0]         led_mode_q, led_mode_d;
   logic [1:0]         src_q, src_d;
   logic [1:0]         pat_idx_q, pat_idx_d;
   logic [5:0]         ramp_idx_q, ramp_idx_d;
   logic [3:0]         sine_idx_q, sine_idx_d;

   logic        btn_trig;
   logic        start_frame;
   logic [11:0] frame_val;

   always_comb begin
      btn_s1_d = start_btn;
      btn_s2_d = btn_s1_q;
`ifdef START_DEBOUNCE_EN
      // One trigger per press: fire once after the run length, re-arm on release.
      db_cnt_d   = db_cnt_q;
      db_fired_d = db_fired_q;
      btn_trig   = 1'b0;
      if (!btn_s2_q) begin
         db_cnt_d   = '0;
         db_fired_d = 1'b0;
      end else if (!db_fired_q) begin
         if (db_cnt_q == c_db_last) begin
            btn_trig   = 1'b1;
            db_fired_d = 1'b1;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
`else
      btn_prev_d = btn_s2_q;
      btn_trig   = btn_s2_q & ~btn_prev_q;
`endif

      case (mode_sw)
         2'b00:   frame_val = {data_sw, 4'h0};
         2'b01:   frame_val = pat_lut(pat_idx_q);
         2'b10:   frame_val = {ramp_idx_q, 6'b0};
         default: frame_val = sine_lut(sine_idx_q);
      endcase
      start_frame = (mode_sw == 2'b00) ? btn_trig : 1'b1;

      state_d    = state_q;
      shreg_d    = shreg_q;
      div_d      = div_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      gap_d      = gap_q;
      cs_n_d     = cs_n_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      busy_d     = busy_q;
      src_d      = src_q;
      pat_idx_d  = pat_idx_q;
      ramp_idx_d = ramp_idx_q;
      sine_idx_d = sine_idx_q;
      led_mode_d = mode_sw;

      case (state_q)
         ST_IDLE: begin
            if (start_frame) begin
               state_d = ST_SHIFT;
               shreg_d = {4'h0, frame_val};
               mosi_d  = shreg_d[15];
               div_d   = clk_div_sw;
               src_d   = mode_sw;
               cnt_d   = 4'd0;
               bit_d   = 4'd0;
               cs_n_d  = 1'b0;
               sclk_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == div_q) begin
               cnt_d = 4'd0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == 4'd15) begin
                     state_d = ST_GAP;
                     cs_n_d  = 1'b1;
                     mosi_d  = 1'b0;
                     gap_d   = '0;
                     case (src_q)
                        2'b01:   pat_idx_d  = pat_idx_q + 2'd1;
                        2'b10:   ramp_idx_d = ramp_idx_q + 6'd1;
                        2'b11:   sine_idx_d = sine_idx_q + 4'd1;
                        default: ;
                     endcase
                  end else begin
                     // Next bit is presented on the falling edge, while SCLK is low.
                     bit_d   = bit_q + 4'd1;
                     mosi_d  = shreg_q[14];
                     shreg_d = {shreg_q[14:0], 1'b0};
                  end
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_GAP: begin
            if (gap_q == c_gap_last) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         btn_s1_q   <= 1'b0;
         btn_s2_q   <= 1'b0;
`ifdef START_DEBOUNCE_EN
         db_cnt_q   <= '0;
         db_fired_q <= 1'b0;
`else
         btn_prev_q <= 1'b0;
`endif
         state_q    <= ST_IDLE;
         shreg_q    <= 16'h0000;
         div_q      <= 4'd0;
         cnt_q      <= 4'd0;
         bit_q      <= 4'd0;
         gap_q      <= '0;
         cs_n_q     <= 1'b1;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         led_mode_q <= 2'b00;
         src_q      <= 2'b00;
         pat_idx_q  <= 2'd0;
         ramp_idx_q <= 6'd0;
         sine_idx_q <= 4'd0;
      end else begin
         btn_s1_q   <= btn_s1_d;
         btn_s2_q   <= btn_s2_d;
`ifdef START_DEBOUNCE_EN
         db_cnt_q   <= db_cnt_d;
         db_fired_q <= db_fired_d;
`else
         btn_prev_q <= btn_prev_d;
`endif
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         gap_q      <= gap_d;
         cs_n_q     <= cs_n_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         led_mode_q <= led_mode_d;
         src_q      <= src_d;
         pat_idx_q  <= pat_idx_d;
         ramp_idx_q <= ramp_idx_d;
         sine_idx_q <= sine_idx_d;
      end
   end

   assign led_busy = busy_q;
   assign led_mode = led_mode_q;
   assign spi_cs_n = cs_n_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_master_top                                               |
// | Brief    : Randomized self-checking bench for spi_master_top; a pin-level  |
// |            monitor decodes frames and a reference model predicts them.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_spi_master_top;
   localparam int c_gap = 16;
   localparam int c_db  = 8;
`ifdef START_DEBOUNCE_EN
   localparam int c_lat_lim = 3 + c_db;
`else
   localparam int c_lat_lim = 4;
`endif

   logic       clk = 1'b0;
   logic       rst_btn;
   logic [1:0] mode_sw;
   logic       start_btn;
   logic [3:0] clk_div_sw;
   logic [7:0] data_sw;
   logic       led_busy;
   logic [1:0] led_mode;
   logic       spi_cs_n;
   logic       spi_sclk;
   logic       spi_mosi;

   spi_master_top #(.DEBOUNCE_CYCLES(c_db), .GAP_CYCLES(c_gap)) dut (
      .clk        (clk),
      .rst_btn    (rst_btn),
      .mode_sw    (mode_sw),
      .start_btn  (start_btn),
      .clk_div_sw (clk_div_sw),
      .data_sw    (data_sw),
      .led_busy   (led_busy),
      .led_mode   (led_mode),
      .spi_cs_n   (spi_cs_n),
      .spi_sclk   (spi_sclk),
      .spi_mosi   (spi_mosi)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [15:0] got;
      logic [15:0] exp;
      logic [1:0]  mode;
      logic [7:0]  data;
      logic [3:0]  d;
      int          low;
      int          nrise;
      int          hp_min;
      int          hp_max;
      int          spacing;
      int          gap_busy;
      bit          has_prev;
      bit          prev_auto;
      bit          mosi_bad;
      bit          busy_bad;
   } frame_t;

   frame_t      mon_q[$];
   logic [11:0] sine_tab[16] = '{12'h800, 12'hB0F, 12'hDA7, 12'hF63, 12'hFFF, 12'hF63,
                                 12'hDA7, 12'hB0F, 12'h800, 12'h4F1, 12'h259, 12'h09D,
                                 12'h001, 12'h09D, 12'h259, 12'h4F1};
   int          idx[4];
   int          n_vec = 0;
   int          n_err = 0;

   function automatic logic [15:0] model_word(input logic [1:0] m, input logic [7:0] data,
                                              input int k);
      case (m)
         2'b00:   return {4'h0, data, 4'h0};
         2'b01:   return 16'((k % 4) * 'h555);
         2'b10:   return 16'((k * 'h40) % 'h1000);
         default: return {4'h0, sine_tab[k % 16]};
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pin-level monitor: decodes each completed frame and attaches the model's prediction.
   frame_t      cur;
   logic [15:0] sh;
   logic        prev_cs, prev_sclk, prev_mosi;
   logic [1:0]  prev_mode;
   int          run, hi_run, busy_hi;
   bit          in_frame, have_prev;

   always @(negedge clk) begin
      if (!rst_btn) begin
         in_frame  = 0;
         have_prev = 0;
         prev_mode = 2'b00;
         hi_run    = 0;
         busy_hi   = 0;
         for (int i = 0; i < 4; i++) idx[i] = 0;
      end else begin
         if (prev_cs && !spi_cs_n) begin
            cur.mode      = mode_sw;
            cur.data      = data_sw;
            cur.d         = clk_div_sw;
            cur.low       = 0;
            cur.nrise     = 0;
            cur.hp_min    = 1000;
            cur.hp_max    = 0;
            cur.spacing   = hi_run;
            cur.gap_busy  = busy_hi;
            cur.has_prev  = have_prev;
            cur.prev_auto = have_prev && (prev_mode != 2'b00);
            cur.mosi_bad  = 0;
            cur.busy_bad  = 0;
            sh            = 16'h0000;
            run           = 0;
            in_frame      = 1;
         end
         if (in_frame && !spi_cs_n) begin
            cur.low++;
            if (led_busy !== 1'b1) cur.busy_bad = 1;
            if (spi_sclk && !prev_sclk) begin
               sh = {sh[14:0], spi_mosi};
               cur.nrise++;
            end
            if (spi_sclk && (spi_mosi !== prev_mosi)) cur.mosi_bad = 1;
            if (spi_sclk != prev_sclk) begin
               if (run < cur.hp_min) cur.hp_min = run;
               if (run > cur.hp_max) cur.hp_max = run;
               run = 1;
            end else begin
               run++;
            end
         end else if (in_frame) begin
            if (run < cur.hp_min) cur.hp_min = run;
            if (run > cur.hp_max) cur.hp_max = run;
            cur.got = sh;
            cur.exp = model_word(cur.mode, cur.data, idx[cur.mode]);
            if (cur.mode != 2'b00) idx[cur.mode]++;
            mon_q.push_back(cur);
            in_frame  = 0;
            have_prev = 1;
            prev_mode = cur.mode;
            hi_run    = 1;
            busy_hi   = led_busy ? 1 : 0;
         end else begin
            hi_run++;
            if (led_busy) busy_hi++;
         end
      end
      prev_cs   = spi_cs_n;
      prev_sclk = spi_sclk;
      prev_mosi = spi_mosi;
   end

   task automatic check_frame(input frame_t fr, input string tag);
      int hp;
      hp = int'(fr.d) + 1;
      check_val({tag, "_word"}, 32'(fr.got), 32'(fr.exp));
      check_val({tag, "_cslow"}, fr.low, 32 * hp);
      check_val({tag, "_rises"}, fr.nrise, 16);
      check_val({tag, "_hpmin"}, fr.hp_min, hp);
      check_val({tag, "_hpmax"}, fr.hp_max, hp);
      check_val({tag, "_mosi_stable"}, 32'(fr.mosi_bad), 0);
      check_val({tag, "_busy_in_frame"}, 32'(fr.busy_bad), 0);
      if (fr.has_prev) check_val({tag, "_gap_busy"}, fr.gap_busy, c_gap);
      if (fr.prev_auto && fr.mode != 2'b00) check_val({tag, "_spacing"}, fr.spacing, c_gap + 1);
   endtask

   task automatic wait_frames(input int n, input int budget, input string tag);
      int c;
      c = 0;
      while (mon_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (mon_q.size() < n) check_val({tag, "_timeout"}, mon_q.size(), n);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int c;
      c = 0;
      while (led_busy !== 1'b0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (led_busy !== 1'b0) check_val({tag, "_idle_timeout"}, 32'(led_busy), 0);
   endtask

   task automatic press(input int n);
      @(negedge clk);
      #1 start_btn = 1'b1;
      repeat (n) @(negedge clk);
      #1 start_btn = 1'b0;
   endtask

   task automatic press_frame(input logic [7:0] data, input logic [3:0] d, input string tag);
      int     lat;
      frame_t fr;
      @(negedge clk);
      #1 data_sw = data;
      clk_div_sw = d;
      @(negedge clk);
      #1 start_btn = 1'b1;
      lat = 99;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (spi_cs_n === 1'b0 && lat == 99) lat = i;
      end
      #1 start_btn = 1'b0;
      check_val({tag, "_latency_ok"}, 32'(lat <= c_lat_lim), 1);
      wait_frames(1, 2000, tag);
      if (mon_q.size() > 0) begin
         fr = mon_q.pop_front();
         check_val({tag, "_mode"}, 32'(fr.mode), 0);
         check_frame(fr, tag);
      end
      wait_idle(200, tag);
   endtask

   task automatic run_auto(input logic [1:0] m, input int n, input bit rand_d,
                           input logic [3:0] d, input string tag);
      frame_t fr;
      @(negedge clk);
      #1 mode_sw = m;
      clk_div_sw = d;
      for (int i = 0; i < n; i++) begin
         wait_frames(1, 2000, tag);
         if (mon_q.size() == 0) return;
         fr = mon_q.pop_front();
         check_frame(fr, $sformatf("%s%0d", tag, i));
         if (rand_d) begin
            @(negedge clk);
            #1 clk_div_sw = 4'($urandom_range(0, 15));
         end
      end
      check_val({tag, "_led_mode"}, 32'(led_mode), 32'(m));
   endtask

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] man_data[4] = '{8'h55, 8'h12, 8'h34, 8'hFF};
      logic [7:0] tab_data[3] = '{8'hAA, 8'h55, 8'hF0};
      logic [3:0] tab_d[3]    = '{4'd0, 4'd5, 4'd10};
      frame_t     fr;

      rst_btn    = 1'b0;
      mode_sw    = 2'b00;
      start_btn  = 1'b0;
      clk_div_sw = 4'd0;
      data_sw    = 8'h00;
      repeat (3) @(negedge clk);
      check_val("rst_cs_n", 32'(spi_cs_n), 1);
      check_val("rst_sclk", 32'(spi_sclk), 0);
      check_val("rst_mosi", 32'(spi_mosi), 0);
      check_val("rst_busy", 32'(led_busy), 0);
      check_val("rst_led_mode", 32'(led_mode), 0);
      #1 rst_btn = 1'b1;
      repeat (5) @(negedge clk);

      press_frame(8'hAA, 4'd1, "first");
      for (int i = 0; i < 4; i++) press_frame(man_data[i], 4'd1, $sformatf("man%0d", i));
      for (int i = 0; i < 3; i++) press_frame(tab_data[i], tab_d[i], $sformatf("div%0d", i));
      for (int i = 0; i < 6; i++)
         press_frame(8'($urandom), 4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));

      // A second press while the long frame is still shifting must be dropped.
      @(negedge clk);
      #1 data_sw = 8'h3C;
      clk_div_sw = 4'd15;
      press(10);
      repeat (100) @(negedge clk);
      check_val("discard_busy", 32'(led_busy), 1);
      press(10);
      wait_idle(3000, "discard");
      repeat (60) @(negedge clk);
      check_val("discard_cnt", mon_q.size(), 1);
      while (mon_q.size() > 0) begin
         fr = mon_q.pop_front();
         check_frame(fr, "discard");
      end

      // Reset mid-frame: outputs must return to idle without waiting for a clock.
      @(negedge clk);
      #1 data_sw = 8'hBE;
      clk_div_sw = 4'd3;
      @(negedge clk);
      #1 start_btn = 1'b1;
      #300;
      check_val("midrst_pre_cs", 32'(spi_cs_n), 0);
      rst_btn = 1'b0;
      #1;
      check_val("midrst_cs_n", 32'(spi_cs_n), 1);
      check_val("midrst_sclk", 32'(spi_sclk), 0);
      check_val("midrst_mosi", 32'(spi_mosi), 0);
      check_val("midrst_busy", 32'(led_busy), 0);
      start_btn = 1'b0;
      repeat (3) @(negedge clk);
      check_val("midrst_abandon", mon_q.size(), 0);
      #1 rst_btn = 1'b1;
      repeat (5) @(negedge clk);
      press_frame(8'hEF, 4'd3, "post_rst");

      run_auto(2'b01, 5, 1'b0, 4'd0, "pat");
      run_auto(2'b10, 66, 1'b0, 4'd0, "ramp");
      run_auto(2'b11, 17, 1'b1, 4'd2, "sine");
      run_auto(2'b01, 3, 1'b1, 4'd1, "pat2");

      @(negedge clk);
      #1 mode_sw = 2'b00;
      wait_idle(2000, "drain");
      while (mon_q.size() > 0) begin
         fr = mon_q.pop_front();
         check_frame(fr, "drain");
      end
      repeat (80) @(negedge clk);
      check_val("manual_quiet", mon_q.size(), 0);
      check_val("final_led_mode", 32'(led_mode), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
